// File: rtl/fifo_byte_packer.sv
// -----------------------------------------------------------------------------
// fifo_byte_packer
// Read-side consumer of a first-word-fall-through byte FIFO. It pops entries
// and packs PACK_RATIO consecutive lanes into one wide word. The word leaves on
// a valid/ready stream. An explicit flush (or, optionally, an idle timeout)
// emits a partial word together with a lane mask.
//
// Optional feature macro: PACKER_TIMEOUT_EN
//   When defined, an idle counter runs while a partial word sits in FILL. After
//   TIMEOUT_CYCLES cycles without a pop it forces a flush. When undefined, no
//   counter is built and TIMEOUT_CYCLES is unused.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   fifo_empty   in   FIFO empty flag
//   fifo_r_data  in   FIFO head entry, valid whenever fifo_empty=0
//   fifo_rd      out  pop strobe; combinational from state and fifo_empty
//   flush        in   single-cycle request to emit the current partial word
//   m_data       out  packed word; lane 0 sits in the LSBs
//   m_keep       out  lane-valid mask for m_data
//   m_valid      out  output word valid
//   m_ready      in   downstream accept
// -----------------------------------------------------------------------------
module fifo_byte_packer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PACK_RATIO     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_r_data,
  output logic                             fifo_rd,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             m_valid,
  input  logic                             m_ready
);

  localparam int unsigned WORD_W = DATA_WIDTH * PACK_RATIO;
  // Lane count must be able to hold PACK_RATIO itself (full-word keep mask).
  localparam int unsigned CNT_W  = $clog2(PACK_RATIO + 1);

  // Elaboration-time parameter sanity checks.
  if (PACK_RATIO < 2) begin : g_bad_ratio
    $error("fifo_byte_packer: PACK_RATIO must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fifo_byte_packer: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_count;
  logic [WORD_W-1:0]     r_data;
  logic [PACK_RATIO-1:0] r_keep;
  logic                  r_valid;

  logic                  w_fill;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_flush_req;
  logic                  w_flush_take;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [PACK_RATIO-1:0] w_keep_nxt;

  // Pop whenever collecting and the FIFO has data; never during reset.
  assign w_fill  = (r_state == ST_FILL);
  assign w_pop   = w_fill && !fifo_empty && !reset;
  assign fifo_rd = w_pop;

  // Lane count after any same-cycle pop.
  assign w_count_nxt = r_count + CNT_W'(w_pop);
  assign w_last      = w_pop && (r_count == CNT_W'(PACK_RATIO - 1));

  // A flush only matters with something to send; a completing pop wins and
  // consumes the flush as an ordinary full word.
  assign w_flush_take = w_fill && w_flush_req && (w_count_nxt != '0) && !w_last;

  // Keep mask: low w_count_nxt bits set (all ones for a full word).
  always_comb begin
    w_keep_nxt = '0;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      w_keep_nxt[i] = (CNT_W'(i) < w_count_nxt);
    end
  end

`ifdef PACKER_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] r_idle;
  logic              w_timeout;

  // Fires on the TIMEOUT_CYCLES-th consecutive pop-less cycle of a partial word.
  assign w_timeout = w_fill && (r_count != '0) && !w_pop &&
                     (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while a partial word waits for more bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle <= '0;
    end else if (!w_fill || w_pop || (r_count == '0) || w_flush_take) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  assign w_flush_req = flush || w_timeout;
`else
  assign w_flush_req = flush;
`endif

  // Packing FSM: FILL collects lanes, HOLD presents the registered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FILL;
      r_count <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            if (w_pop && (r_count == CNT_W'(i))) begin
              r_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_r_data;
            end
          end
          r_count <= w_count_nxt;
          if (w_last || w_flush_take) begin
            r_state <= ST_HOLD;
            r_valid <= 1'b1;
            r_keep  <= w_keep_nxt;
          end
        end
        ST_HOLD: begin
          // Lanes clear on handshake so unfilled lanes of the next word are 0.
          if (m_ready) begin
            r_state <= ST_FILL;
            r_valid <= 1'b0;
            r_keep  <= '0;
            r_data  <= '0;
            r_count <= '0;
          end
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  assign m_data  = r_data;
  assign m_keep  = r_keep;
  assign m_valid = r_valid;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Testbench for fifo_byte_packer: queue-modelled FWFT FIFO feeding the packer,
// table-driven transactions, hand-written corner sequences and a random stream.
module tb_fifo_byte_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned PR = 4;
  localparam int unsigned WW = DW * PR;
  localparam int          NV = 7;
  localparam int          NR = 203;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_r_data;
  logic          fifo_rd;
  logic          flush;
  logic [WW-1:0] m_data;
  logic [PR-1:0] m_keep;
  logic          m_valid;
  logic          m_ready;

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;

  typedef struct packed {
    logic [WW-1:0] d;
    logic [PR-1:0] k;
  } beat_t;

  typedef struct {
    int          n;        // bytes written
    logic [63:0] b;        // byte i at [8i+:8]
    int          stall;    // cycles with m_ready=0 at start
    bit          do_flush; // flush after the FIFO drains
    int          nb;       // expected beats
    logic [63:0] exp_d;    // beat j at [32j+:32]
    logic [7:0]  exp_k;    // keep j at [4j+:4]
  } vec_t;

  logic [7:0] fq[$];
  beat_t      got[$];

  logic          hold_prev = 1'b0;
  logic [WW-1:0] d_prev;
  logic [PR-1:0] k_prev;
  logic          s_rd;
  logic          s_mv;

  always #5 clk = ~clk;

  fifo_byte_packer dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_rd     (fifo_rd),
    .flush       (flush),
    .m_data      (m_data),
    .m_keep      (m_keep),
    .m_valid     (m_valid),
    .m_ready     (m_ready)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endfunction

  function automatic logic [WW-1:0] kmask(logic [PR-1:0] k);
    logic [WW-1:0] m;
    m = '0;
    for (int i = 0; i < PR; i++) if (k[i]) m[i*DW +: DW] = '1;
    return m;
  endfunction

  task automatic refresh();
    fifo_empty  = (fq.size() == 0);
    fifo_r_data = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  // One clock: sample pre-edge values at the edge, then update the FIFO model.
  task automatic cyc();
    logic          rd, mv, mr, rs;
    logic [WW-1:0] d;
    logic [PR-1:0] k;
    beat_t         bb;
    @(posedge clk);
    rd = fifo_rd; mv = m_valid; mr = m_ready; rs = reset; d = m_data; k = m_keep;
    cyc_no++;
    s_rd = rd; s_mv = mv;
    if (rs) begin
      chk("rd_in_reset", 32'(rd), 32'd0);
    end else begin
      chk("rd_rule", 32'(rd), 32'(!mv && !fifo_empty));
      if (hold_prev) begin
        chk("hold_valid", 32'(mv), 32'd1);
        chk("hold_data", d, d_prev);
        chk("hold_keep", 32'(k), 32'(k_prev));
      end
      if (mv) chk("unfilled_zero", d & ~kmask(k), 32'd0);
    end
    hold_prev = !rs && mv && !mr;
    d_prev = d; k_prev = k;
    #1;
    if (rd && !rs) void'(fq.pop_front());
    if (mv && mr && !rs) begin
      bb.d = d; bb.k = k;
      got.push_back(bb);
    end
    refresh();
  endtask

  task automatic wait_idle(string name, int n);
    int i;
    for (i = 0; i < n; i++) begin
      if (fq.size() == 0 && !m_valid) break;
      cyc();
    end
    total++;
    if (i == n) begin
      bad++;
      $display("FAIL %s: idle not reached within %0d cycles", name, n);
    end
  endtask

  task automatic expect_one(string name, logic [WW-1:0] d, logic [PR-1:0] k);
    chk({name, "_nbeats"}, 32'(got.size()), 32'd1);
    if (got.size() >= 1) begin
      chk({name, "_data"}, got[0].d, d);
      chk({name, "_keep"}, 32'(got[0].k), 32'(k));
    end
    got.delete();
  endtask

  task automatic push(logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  initial begin
    vec_t          vt[NV];
    logic [7:0]    sent[$];
    logic [7:0]    b;
    logic [WW-1:0] ed;
    logic [PR-1:0] ek;
    int            gap, c, pop_at, rise_at, nexp;

    reset = 1'b1; flush = 1'b0; m_ready = 1'b1;
    refresh();

    // Reset state
    cyc(); cyc();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_keep", 32'(m_keep), 32'd0);
    reset = 1'b0;
    cyc();

    vt[0] = '{4, 64'h00000000_00020805,  0, 1'b0, 1, 64'h00000000_00020805, 8'h0F};
    vt[1] = '{8, 64'h05040703_01060309, 20, 1'b0, 2, 64'h05040703_01060309, 8'hFF};
    vt[2] = '{3, 64'h00000000_00060309,  0, 1'b1, 1, 64'h00000000_00060309, 8'h07};
    vt[3] = '{1, 64'h00000000_000000AA,  0, 1'b1, 1, 64'h00000000_000000AA, 8'h01};
    vt[4] = '{5, 64'h00000005_04030201,  0, 1'b1, 2, 64'h00000005_04030201, 8'h1F};
    vt[5] = '{2, 64'h00000000_00002211,  0, 1'b1, 1, 64'h00000000_00002211, 8'h03};
    vt[6] = '{6, 64'h0000C6C5_C4C3C2C1,  5, 1'b1, 2, 64'h0000C6C5_C4C3C2C1, 8'h3F};

    for (int t = 0; t < NV; t++) begin
      m_ready = (vt[t].stall == 0);
      for (int j = 0; j < vt[t].n; j++) fq.push_back(vt[t].b[8*j +: 8]);
      refresh();
      repeat (vt[t].stall) cyc();
      m_ready = 1'b1;
      wait_idle($sformatf("v%0d_drain", t), 200);
      if (vt[t].do_flush) begin
        flush = 1'b1; cyc(); flush = 1'b0;
        wait_idle($sformatf("v%0d_flush", t), 20);
      end
      repeat (2) cyc();
      chk($sformatf("v%0d_nbeats", t), 32'(got.size()), 32'(vt[t].nb));
      for (int j = 0; j < vt[t].nb && j < got.size(); j++) begin
        chk($sformatf("v%0d_data%0d", t, j), got[j].d, vt[t].exp_d[32*j +: 32]);
        chk($sformatf("v%0d_keep%0d", t, j), 32'(got[j].k), 32'(vt[t].exp_k[4*j +: 4]));
      end
      got.delete();
    end

    // Flush with nothing collected is ignored and not remembered
    flush = 1'b1; cyc(); flush = 1'b0;
    repeat (5) cyc();
    chk("idle_flush_nbeats", 32'(got.size()), 32'd0);
    chk("idle_flush_valid", 32'(m_valid), 32'd0);
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    wait_idle("idle_flush_drain", 50);
    repeat (2) cyc();
    expect_one("after_idle_flush", 32'h44434241, 4'hF);

    // Flush coinciding with the completing pop yields one full word
    push(8'h07); push(8'h04); push(8'h05);
    repeat (3) cyc();
    push(8'h06);
    flush = 1'b1; cyc(); flush = 1'b0;
    wait_idle("flush_full_drain", 20);
    repeat (3) cyc();
    expect_one("flush_full", 32'h06050407, 4'hF);

    // Flush together with a non-completing pop includes that byte
    push(8'h31);
    cyc();
    push(8'h32);
    flush = 1'b1; cyc(); flush = 1'b0;
    wait_idle("flush_pop_drain", 20);
    repeat (2) cyc();
    expect_one("flush_pop", 32'h00003231, 4'h3);

    // Flush while holding a word is ignored
    m_ready = 1'b0;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    repeat (6) cyc();
    chk("hold_flush_valid", 32'(m_valid), 32'd1);
    flush = 1'b1; cyc(); flush = 1'b0;
    repeat (3) cyc();
    m_ready = 1'b1;
    wait_idle("hold_flush_drain", 20);
    repeat (5) cyc();
    expect_one("hold_flush", 32'h54535251, 4'hF);

    // Reset discards a partial word
    push(8'h01); push(8'h02);
    repeat (3) cyc();
    reset = 1'b1; cyc();
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_data", m_data, 32'd0);
    chk("mid_rst_keep", 32'(m_keep), 32'd0);
    reset = 1'b0;
    push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D);
    wait_idle("rst_drain", 50);
    repeat (2) cyc();
    expect_one("after_rst", 32'h0D0C0B0A, 4'hF);

    // Idle timeout behaviour
    push(8'h07);
`ifdef PACKER_TIMEOUT_EN
    pop_at = -1; rise_at = -1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (pop_at < 0 && s_rd) pop_at = cyc_no;
      if (rise_at < 0 && s_mv) rise_at = cyc_no;
    end
    chk("timeout_seen", 32'(rise_at >= 0 && pop_at >= 0), 32'd1);
    chk("timeout_latency", 32'(rise_at - pop_at), 32'd17);
    expect_one("timeout", 32'h00000007, 4'h1);
`else
    repeat (100) cyc();
    chk("no_timeout_nbeats", 32'(got.size()), 32'd0);
    chk("no_timeout_valid", 32'(m_valid), 32'd0);
    flush = 1'b1; cyc(); flush = 1'b0;
    wait_idle("no_timeout_flush", 20);
    repeat (2) cyc();
    expect_one("no_timeout", 32'h00000007, 4'h1);
`endif

    // Random stream with random backpressure against a lane-grouping model
    gap = 0; c = 0;
    while (sent.size() < NR && c < 5000) begin
      if ($urandom_range(0, 1) == 1 || gap >= 6) begin
        b = 8'($urandom);
        fq.push_back(b);
        sent.push_back(b);
        gap = 0;
      end else begin
        gap++;
      end
      m_ready = ($urandom_range(0, 9) < 7);
      refresh();
      cyc();
      c++;
    end
    m_ready = 1'b1;
    wait_idle("rand_drain", 500);
    flush = 1'b1; cyc(); flush = 1'b0;
    wait_idle("rand_flush", 20);
    repeat (2) cyc();
    nexp = (NR + PR - 1) / PR;
    chk("rand_nbeats", 32'(got.size()), 32'(nexp));
    for (int j = 0; j < nexp && j < got.size(); j++) begin
      ed = '0; ek = '0;
      for (int l = 0; l < PR; l++) begin
        if (j*PR + l < NR) begin
          ed[l*DW +: DW] = sent[j*PR + l];
          ek[l] = 1'b1;
        end
      end
      chk($sformatf("rand_data%0d", j), got[j].d, ed);
      chk($sformatf("rand_keep%0d", j), 32'(got[j].k), 32'(ek));
    end
    got.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
